// File: rtl/anomaly_alarm_filter.sv
// Windowed anomaly accumulator with a confirm/hysteresis alarm FSM and a sticky host interrupt.
// Every window is WINDOW valid samples long. The FSM is evaluated only when a window closes.
module anomaly_alarm_filter #(
    parameter int WINDOW    = 16,
    parameter int CNT_W     = 5,
    parameter int THRESH_HI = 4,
    parameter int THRESH_LO = 1,
    parameter int CONFIRM   = 2,
    parameter int TOTAL_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sample_valid,
    input  logic               anomaly_in,
    input  logic               irq_ack,
    output logic               alarm,
    output logic               irq,
    output logic [CNT_W-1:0]   window_anoms,
    output logic               window_done,
    output logic [TOTAL_W-1:0] total_anoms
);

    localparam int STREAK_W = $clog2(CONFIRM + 1);
    localparam logic [CNT_W-1:0]    LAST_IDX = CNT_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0]    HI       = CNT_W'(THRESH_HI);
    localparam logic [CNT_W-1:0]    LO       = CNT_W'(THRESH_LO);
    localparam logic [STREAK_W-1:0] CONF     = STREAK_W'(CONFIRM);

    typedef enum logic [1:0] {
        CLEAR   = 2'd0,
        PENDING = 2'd1,
        ALARM   = 2'd2
    } state_t;

    state_t              state, state_next;
    logic [STREAK_W-1:0] streak, streak_next;
    logic [CNT_W-1:0]    sample_cnt;
    logic [CNT_W-1:0]    acc;
    logic [CNT_W-1:0]    n;
    logic                closing;
    logic                hot;
    logic                cool;
    logic                enter_alarm;

    function automatic logic [TOTAL_W-1:0] sat_inc(input logic [TOTAL_W-1:0] v);
        return (&v) ? v : v + TOTAL_W'(1);
    endfunction

    // The closing sample is itself counted into n.
    assign closing = sample_valid && (sample_cnt == LAST_IDX);
    assign n       = acc + {{(CNT_W-1){1'b0}}, anomaly_in};
    assign hot     = (n >= HI);
    assign cool    = (n <= LO);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= CLEAR;
            streak <= '0;
        end else begin
            state  <= state_next;
            streak <= streak_next;
        end
    end

    always_comb begin
        state_next  = state;
        streak_next = streak;
        if (closing) begin
            case (state)
                CLEAR: begin
                    if (hot) begin
                        if (CONFIRM == 1) begin
                            state_next = ALARM;
                        end else begin
                            state_next  = PENDING;
                            streak_next = STREAK_W'(1);
                        end
                    end
                end
                PENDING: begin
                    if (hot) begin
                        if (streak + STREAK_W'(1) == CONF) begin
                            state_next  = ALARM;
                            streak_next = '0;
                        end else begin
                            streak_next = streak + STREAK_W'(1);
                        end
                    end else begin
                        state_next  = CLEAR;
                        streak_next = '0;
                    end
                end
                ALARM: begin
                    if (cool) begin
                        state_next  = CLEAR;
                        streak_next = '0;
                    end
                end
                default: begin
                    state_next  = CLEAR;
                    streak_next = '0;
                end
            endcase
        end
    end

    always_comb begin
        enter_alarm = (state != ALARM) && (state_next == ALARM);
        alarm       = (state == ALARM);
    end

    // Interrupt: a new alarm entry wins over a simultaneous acknowledge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq <= 1'b0;
        end else if (enter_alarm) begin
            irq <= 1'b1;
        end else if (irq_ack) begin
            irq <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sample_cnt   <= '0;
            acc          <= '0;
            window_anoms <= '0;
            window_done  <= 1'b0;
        end else begin
            window_done <= 1'b0;
            if (closing) begin
                window_anoms <= n;
                window_done  <= 1'b1;
                sample_cnt   <= '0;
                acc          <= '0;
            end else if (sample_valid) begin
                sample_cnt <= sample_cnt + CNT_W'(1);
                acc        <= n;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            total_anoms <= '0;
        end else if (sample_valid && anomaly_in) begin
            total_anoms <= sat_inc(total_anoms);
        end
    end

endmodule

// File: tb/tb_anomaly_alarm_filter.sv
// Directed bench for anomaly_alarm_filter: window timing, confirm/hysteresis alarm, irq, saturation.
// A second instance with TOTAL_W=4 exercises lifetime-counter saturation.
module tb_anomaly_alarm_filter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sample_valid = 1'b0;
    logic        anomaly_in = 1'b0;
    logic        irq_ack = 1'b0;
    logic        alarm, irq, window_done;
    logic [4:0]  window_anoms;
    logic [15:0] total_anoms;

    logic        sv2 = 1'b0;
    logic        an2 = 1'b0;
    logic        alarm2, irq2, window_done2;
    logic [4:0]  window_anoms2;
    logic [3:0]  total_anoms2;

    int errors = 0;
    int checks = 0;
    int exp_total = 0;

    always #5 clk = ~clk;

    anomaly_alarm_filter dut (
        .clk(clk), .reset(reset), .sample_valid(sample_valid), .anomaly_in(anomaly_in),
        .irq_ack(irq_ack), .alarm(alarm), .irq(irq), .window_anoms(window_anoms),
        .window_done(window_done), .total_anoms(total_anoms)
    );

    anomaly_alarm_filter #(.TOTAL_W(4)) dut_sat (
        .clk(clk), .reset(reset), .sample_valid(sv2), .anomaly_in(an2),
        .irq_ack(1'b0), .alarm(alarm2), .irq(irq2), .window_anoms(window_anoms2),
        .window_done(window_done2), .total_anoms(total_anoms2)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, return 1 time unit after the posedge.
    task automatic step(input logic v, input logic a, input logic ack);
        @(negedge clk);
        sample_valid = v;
        anomaly_in   = a;
        irq_ack      = ack;
        @(posedge clk);
        #1;
        if (v && a) exp_total++;
    endtask

    // Full window of 16 samples, first k anomalous; ack optionally held on the closing sample.
    task automatic win(input int k, input logic ack_last, input string tag);
        for (int i = 0; i < 16; i++) begin
            step(1'b1, (i < k), (i == 15) ? ack_last : 1'b0);
            if (i == 14) check({tag, " done_early"}, int'(window_done), 0);
        end
        check({tag, " done"}, int'(window_done), 1);
        check({tag, " anoms"}, int'(window_anoms), k);
    endtask

    initial begin
        // Reset state
        #12;
        check("rst alarm", int'(alarm), 0);
        check("rst irq", int'(irq), 0);
        check("rst anoms", int'(window_anoms), 0);
        check("rst done", int'(window_done), 0);
        check("rst total", int'(total_anoms), 0);
        @(negedge clk);
        reset = 1'b1;

        // Two hot windows -> PENDING then ALARM
        win(4, 1'b0, "w2a");
        check("w2a alarm", int'(alarm), 0);
        step(1'b0, 1'b0, 1'b0);
        check("done pulse clears", int'(window_done), 0);
        check("anoms hold", int'(window_anoms), 4);
        win(4, 1'b0, "w2b");
        check("w2b alarm", int'(alarm), 1);
        check("w2b irq", int'(irq), 1);
        check("w2b total", int'(total_anoms), exp_total);

        // Async reset mid-window, mid-cycle
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
        check("pre-rst total", int'(total_anoms), exp_total);
        #2;
        reset = 1'b0;
        #1;
        exp_total = 0;
        check("async alarm", int'(alarm), 0);
        check("async irq", int'(irq), 0);
        check("async anoms", int'(window_anoms), 0);
        check("async done", int'(window_done), 0);
        check("async total", int'(total_anoms), 0);
        @(negedge clk);
        sample_valid = 1'b0;
        anomaly_in   = 1'b0;
        reset        = 1'b1;
        win(0, 1'b0, "fresh");
        check("fresh alarm", int'(alarm), 0);

        // Streak broken by a 3-count window
        win(4, 1'b0, "s4a");
        check("s4a alarm", int'(alarm), 0);
        win(3, 1'b0, "s3");
        check("s3 alarm", int'(alarm), 0);
        win(4, 1'b0, "s4b");
        check("s4b alarm", int'(alarm), 0);
        win(4, 1'b0, "s4c");
        check("s4c alarm", int'(alarm), 1);
        check("s4c irq", int'(irq), 1);

        // Hysteresis and irq acknowledge
        win(2, 1'b0, "h2");
        check("h2 alarm", int'(alarm), 1);
        win(1, 1'b0, "h1");
        check("h1 alarm", int'(alarm), 0);
        check("h1 irq sticky", int'(irq), 1);
        step(1'b0, 1'b0, 1'b0);
        check("irq holds", int'(irq), 1);
        step(1'b0, 1'b0, 1'b1);
        check("irq acked", int'(irq), 0);
        step(1'b0, 1'b0, 1'b1);
        check("ack noop", int'(irq), 0);

        // Set beats simultaneous ack
        win(4, 1'b0, "a4a");
        check("a4a alarm", int'(alarm), 0);
        win(4, 1'b1, "a4b");
        check("a4b alarm", int'(alarm), 1);
        check("set wins irq", int'(irq), 1);
        step(1'b0, 1'b0, 1'b1);
        check("ack after set", int'(irq), 0);

        // anomaly_in without sample_valid is ignored
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 1'b0);
            if (window_done !== 1'b0) check("noise done", int'(window_done), 0);
        end
        check("noise total", int'(total_anoms), exp_total);
        win(0, 1'b0, "after noise");
        check("cool clears alarm", int'(alarm), 0);

        // Saturation on the TOTAL_W=4 instance
        check("sat start", int'(total_anoms2), 0);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            sv2 = 1'b1;
            an2 = 1'b1;
            @(posedge clk);
            #1;
            if (i == 14) check("sat 14", int'(total_anoms2), 14);
            if (i == 15) check("sat 15", int'(total_anoms2), 15);
        end
        check("sat hold", int'(total_anoms2), 15);
        @(negedge clk);
        sv2 = 1'b0;
        an2 = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
